mem_arbiter: RTL

//  Shares the single-port 64kB behavioural memory between two requesters:

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_prio.sv | 53 +++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter slice: FSM state encoding and
//   requester port indices used by mem_arbiter and mem_arbiter_prio.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Requester indices; also the bit positions inside the one-hot grant.
    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

endpackage

// File: rtl/mem_arbiter_prio.sv
// ---------------------------------------------------------------------------
// mem_arbiter_prio
//   Fixed priority (CPU first) with a starvation guard for the DMA port.
//   The counter tracks consecutive CPU grants taken while the DMA port was
//   waiting; once it reaches STARVE_LIMIT the DMA port wins the next grant.
// Ports
//   clk, resetn    clock / synchronous active-low reset
//   req0, req1     CPU / DMA request
//   grant_strobe   high on the cycle the arbiter commits to the winner
//   winner         one-hot winner (bit PORT_CPU / PORT_DMA), 00 if no request
// ---------------------------------------------------------------------------
module mem_arbiter_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0,
    input  logic       req1,
    input  logic       grant_strobe,
    output logic [1:0] winner
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;

    always_comb begin
        winner = 2'b00;
        if (req1 && (!req0 || starve_cnt == LIMIT))
            winner[PORT_DMA] = 1'b1;
        else if (req0)
            winner[PORT_CPU] = 1'b1;
    end

    // Clears whenever the DMA port is not asking, so it only ever measures
    // one uninterrupted wait. Saturates at LIMIT.
    always_ff @(posedge clk) begin
        if (!resetn)
            starve_cnt <= '0;
        else if (!req1)
            starve_cnt <= '0;
        else if (grant_strobe) begin
            if (winner[PORT_DMA])
                starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between the 6502 bus interface (port 0)
//   and the loader/debug DMA (port 1). Each access runs IDLE -> ISSUE ->
//   (WAIT) -> RESP; completion is a one-cycle ack on the owning port.
// Ports
//   clk, resetn                 clock / synchronous active-low reset
//   req*, we*, addr*, wdata*    requester side; held stable until ack
//   ack*, rdata*                one-cycle completion, read data (held)
//   grant                       one-hot owner of the transaction, 00 = idle
//   mem_*                       memory interface; only driven from here
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [1:0]        grant,
    output logic              mem_enable,
    output logic              mem_wr_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    localparam int WCW = $clog2(RD_LATENCY + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(RD_LATENCY - 1);

    arb_state_t     state;
    logic           owner;      // 1 = DMA port owns the transaction
    logic           cur_we;
    logic [WCW-1:0] wait_cnt;
    logic [1:0]     winner;
    logic           grant_strobe;
    mem_req_t       sel_req;

    assign grant_strobe = (state == ST_IDLE) && (req0 || req1);

    always_comb begin
        sel_req = winner[PORT_DMA] ? '{we: we1, addr: addr1, wdata: wdata1}
                                   : '{we: we0, addr: addr0, wdata: wdata0};
    end

    mem_arbiter_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk          (clk),
        .resetn       (resetn),
        .req0         (req0),
        .req1         (req1),
        .grant_strobe (grant_strobe),
        .winner       (winner)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            owner         <= 1'b0;
            cur_we        <= 1'b0;
            wait_cnt      <= '0;
            grant         <= 2'b00;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            rdata0        <= '0;
            rdata1        <= '0;
            mem_enable    <= 1'b0;
            mem_wr_enable <= 1'b0;
            mem_address   <= '0;
            mem_wr_data   <= '0;
        end else begin
            // Pulses default low; set only on the transition that needs them.
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            mem_enable    <= 1'b0;
            mem_wr_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_strobe) begin
                        owner         <= winner[PORT_DMA];
                        cur_we        <= sel_req.we;
                        grant         <= winner;
                        mem_enable    <= 1'b1;
                        mem_wr_enable <= sel_req.we;
                        mem_address   <= sel_req.addr;
                        mem_wr_data   <= sel_req.wdata;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Memory samples the access on the edge that leaves ISSUE.
                    if (cur_we) begin
                        if (owner) ack1 <= 1'b1;
                        else       ack0 <= 1'b1;
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (owner) begin
                            rdata1 <= mem_rd_data;
                            ack1   <= 1'b1;
                        end else begin
                            rdata0 <= mem_rd_data;
                            ack0   <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ST_RESP: begin
                    grant <= 2'b00;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
